cnn_conv_stream: RTL

//  Parametrised streaming KxK single-channel convolution engine; next generation of cnn_top.

---
 rtl/cnn_pkg.sv | 34 +++
 rtl/cnn_line_buffer.sv | 31 +++
 rtl/cnn_conv_stream.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming convolution engine.
package cnn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Width of one window result: full product plus growth for K*K terms.
   function automatic int unsigned conv_w(input int unsigned k, input int unsigned data_w);
      return 2 * data_w + $clog2(k * k);
   endfunction

   // Signed add clamped to the range of an acc_w-bit signed register (acc_w <= 62).
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned        acc_w);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi) begin
         return hi;
      end else if (s < lo) begin
         return lo;
      end
      return s;
   endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One image row of delay: emits the pixel accepted IMG_W accepts earlier.
module cnn_line_buffer
#(
   parameter int unsigned IMG_W  = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     shift_en,
   input  logic signed [DATA_W-1:0] din,
   output logic signed [DATA_W-1:0] dout
);

   logic signed [DATA_W-1:0] mem [IMG_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(IMG_W); i++) begin
            mem[i] <= '0;
         end
      end else if (shift_en) begin
         mem[0] <= din;
         for (int i = 1; i < int'(IMG_W); i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dout = mem[IMG_W-1];

endmodule

// File: rtl/cnn_conv_stream.sv
// Streaming KxK single-channel convolution with saturating frame accumulator.
// Build option: define CNN_RELU_EN to clamp negative window results to zero.
module cnn_conv_stream
   import cnn_pkg::*;
#(
   parameter  int unsigned IMG_W  = 8,
   parameter  int unsigned IMG_H  = 8,
   parameter  int unsigned K      = 3,
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned ACC_W  = 32,
   localparam int unsigned CONV_W = conv_w(K, DATA_W),
   localparam int unsigned AW     = (K * K > 1) ? $clog2(K * K) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     w_we,
   input  logic [AW-1:0]            w_addr,
   input  logic signed [DATA_W-1:0] w_data,
   input  logic                     pix_valid,
   input  logic signed [DATA_W-1:0] pix_data,
   output logic                     pix_ready,
   output logic                     out_valid,
   output logic signed [CONV_W-1:0] out_data,
   output logic signed [ACC_W-1:0]  value,
   output logic                     done,
   output logic                     busy
);

   localparam int unsigned NW = K * K;
   localparam int unsigned CW = $clog2(IMG_W + 1);
   localparam int unsigned RW = $clog2(IMG_H + 1);
   localparam int unsigned PW = 2 * DATA_W;

   state_t state, state_next;
   logic   drain_cnt;
   logic   accept;
   logic   last_pix;
   logic   win_ok;
   logic   flush;

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic signed [DATA_W-1:0] wt  [NW];
   logic signed [DATA_W-1:0] win [K][K];
   logic signed [DATA_W-1:0] tap [K];

   logic                     w_vld;
   logic                     s1_vld;
   logic signed [CONV_W-1:0] s1_sum;
   logic signed [CONV_W-1:0] sum_c;
   logic signed [PW-1:0]     prod;
   logic signed [CONV_W-1:0] res_c;

   assign accept   = pix_valid && pix_ready;
   assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
   assign win_ok   = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
   assign flush    = (state_next == IDLE);

   // State register plus outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pix_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         pix_ready <= (state_next == RUN);
         busy      <= (state_next == RUN) || (state_next == DRAIN);
         done      <= (state_next == DONE);
      end
   end

   // Dropping enable aborts from any busy or done state.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (enable) state_next = RUN;
         RUN: begin
            if (!enable)                 state_next = IDLE;
            else if (accept && last_pix) state_next = DRAIN;
         end
         DRAIN: begin
            if (!enable)       state_next = IDLE;
            else if (drain_cnt) state_next = DONE;
         end
         DONE:  if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain_cnt <= 1'b0;
      end else begin
         drain_cnt <= (state == DRAIN) ? !drain_cnt : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NW); i++) begin
            wt[i] <= '0;
         end
      end else if ((state == IDLE) && w_we && (32'(w_addr) < NW)) begin
         wt[w_addr] <= w_data;
      end
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (state == IDLE) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // tap[g] is the pixel g rows above the incoming one, same column.
   assign tap[0] = pix_data;
   for (genvar g = 1; g < int'(K); g++) begin : g_lb
      cnn_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb (
         .clk      (clk),
         .rst      (rst),
         .shift_en (accept),
         .din      (tap[g-1]),
         .dout     (tap[g])
      );
   end

   // Window: column K-1 is newest, row K-1 is the current image row.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K); c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K) - 1; c++) begin
               win[r][c] <= win[r][c+1];
            end
            win[r][K-1] <= tap[int'(K) - 1 - r];
         end
      end
   end

   always_comb begin
      sum_c = '0;
      prod  = '0;
      for (int r = 0; r < int'(K); r++) begin
         for (int c = 0; c < int'(K); c++) begin
            prod  = PW'(win[r][c]) * PW'(wt[r*int'(K)+c]);
            sum_c = sum_c + CONV_W'(prod);
         end
      end
   end

`ifdef CNN_RELU_EN
   assign res_c = s1_sum[CONV_W-1] ? '0 : s1_sum;
`else
   assign res_c = s1_sum;
`endif

   // Window valid -> registered sum -> output strobe and accumulate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_vld     <= 1'b0;
         s1_vld    <= 1'b0;
         s1_sum    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         value     <= '0;
      end else begin
         w_vld     <= accept && win_ok && !flush;
         s1_vld    <= w_vld && !flush;
         s1_sum    <= sum_c;
         out_valid <= s1_vld && !flush;
         if (s1_vld) begin
            out_data <= res_c;
         end
         if ((state == IDLE) && (state_next == RUN)) begin
            value <= '0;
         end else if (s1_vld && !flush) begin
            value <= ACC_W'(sat_add(64'(value), 64'(res_c), ACC_W));
         end
      end
   end

endmodule
